// File: rtl/dmem_access_unit.sv
// Memory-stage data bus master.
// Takes one load/store per transaction from the pipeline and drives a
// req/gnt/rvalid data bus. Store data is replicated across byte lanes, and
// returned load data is lane-selected and sign/zero extended. Misaligned
// accesses, illegal width codes and bus timeouts produce an error response.
// Every bus field and response field comes straight from a flop.

module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    // The counter only has to count up to TIMEOUT-1, so size it for TIMEOUT.
    localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 32'd0) ? CNT_W'(TIMEOUT - 32'd1) : '0;
    localparam logic TO_EN = (TIMEOUT > 32'd0);

    // Width code is legal for the direction and the address is naturally aligned.
    function automatic logic access_legal(input logic we, input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
        logic code_ok;
        logic align_ok;
        if (we) begin
            code_ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2);
        end else begin
            code_ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                      (func3 == 3'd4) || (func3 == 3'd5);
        end
        case (func3[1:0])
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = (addr_lo[0] == 1'b0);
            2'd2:    align_ok = (addr_lo == 2'b00);
            default: align_ok = 1'b0;
        endcase
        return code_ok && align_ok;
    endfunction

    // Copy the stored byte/half into every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate_store(input logic [2:0] func3,
                                                    input logic [31:0] wdata);
        logic [31:0] result;
        case (func3)
            3'd0:    result = {4{wdata[7:0]}};
            3'd1:    result = {2{wdata[15:0]}};
            default: result = wdata;
        endcase
        return result;
    endfunction

    // Select the addressed byte/half from the bus word and extend it to 32 bits.
    function automatic logic [31:0] format_load(input logic [2:0] func3,
                                                input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        shifted = rdata >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            3'd0:    result = {{24{byte_v[7]}}, byte_v};
            3'd4:    result = {24'd0, byte_v};
            3'd1:    result = {{16{half_v[15]}}, half_v};
            3'd5:    result = {16'd0, half_v};
            3'd2:    result = rdata;
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              req_legal_s;
    logic              timeout_hit_s;

    logic              we_r;
    logic [2:0]        func3_r;
    logic [1:0]        off_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              dbus_req_r;
    logic              dbus_we_r;
    logic [31:0]       dbus_addr_r;
    logic [31:0]       dbus_wdata_r;
    logic [3:0]        dbus_be_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;

    logic              we_s;
    logic [2:0]        func3_s;
    logic [1:0]        off_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              dbus_req_s;
    logic              dbus_we_s;
    logic [31:0]       dbus_addr_s;
    logic [31:0]       dbus_wdata_s;
    logic [3:0]        dbus_be_s;
    logic              rsp_valid_s;
    logic              rsp_err_s;
    logic [31:0]       rsp_rdata_s;

    assign req_ready  = (state_r == ST_IDLE);
    assign dbus_req   = dbus_req_r;
    assign dbus_we    = dbus_we_r;
    assign dbus_addr  = dbus_addr_r;
    assign dbus_wdata = dbus_wdata_r;
    assign dbus_be    = dbus_be_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata  = rsp_rdata_r;

    // Classify the incoming request and detect the last allowed bus cycle.
    always_comb begin
        req_legal_s = access_legal(req_we, req_func3, req_addr[1:0]);
        if (TO_EN && ((state_r == ST_REQ) || (state_r == ST_WAIT_RSP))) begin
            timeout_hit_s = (cnt_r == CNT_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; in WAIT_RSP a response in the timeout cycle takes priority.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = req_legal_s ? ST_REQ : ST_ERR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                end else if (dbus_gnt) begin
                    next_state_s = ST_WAIT_RSP;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT_RSP: begin
                if (dbus_rvalid || timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_RSP;
                end
            end
            ST_ERR: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered bus/response fields; bus fields hold unless loaded.
    always_comb begin
        we_s         = we_r;
        func3_s      = func3_r;
        off_s        = off_r;
        cnt_s        = cnt_r;
        dbus_req_s   = dbus_req_r;
        dbus_we_s    = dbus_we_r;
        dbus_addr_s  = dbus_addr_r;
        dbus_wdata_s = dbus_wdata_r;
        dbus_be_s    = dbus_be_r;
        rsp_valid_s  = 1'b0;
        rsp_err_s    = 1'b0;
        rsp_rdata_s  = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    we_s    = req_we;
                    func3_s = req_func3;
                    off_s   = req_addr[1:0];
                    if (req_legal_s) begin
                        cnt_s       = '0;
                        dbus_req_s  = 1'b1;
                        dbus_we_s   = req_we;
                        dbus_addr_s = {req_addr[31:2], 2'b00};
                        if (req_we) begin
                            dbus_wdata_s = replicate_store(req_func3, req_wdata);
                            dbus_be_s    = req_byte_en;
                        end else begin
                            dbus_wdata_s = 32'd0;
                            dbus_be_s    = 4'b1111;
                        end
                    end else begin
                        dbus_req_s = 1'b0;
                    end
                end else begin
                    dbus_req_s = 1'b0;
                end
            end
            ST_REQ: begin
                cnt_s = TO_EN ? (cnt_r + CNT_W'(1)) : cnt_r;
                if (timeout_hit_s) begin
                    dbus_req_s  = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else if (dbus_gnt) begin
                    dbus_req_s = 1'b0;
                end else begin
                    dbus_req_s = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                cnt_s      = TO_EN ? (cnt_r + CNT_W'(1)) : cnt_r;
                dbus_req_s = 1'b0;
                if (dbus_rvalid) begin
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = we_r ? 32'd0 : format_load(func3_r, off_r, dbus_rdata);
                end else if (timeout_hit_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    rsp_valid_s = 1'b0;
                end
            end
            ST_ERR: begin
                dbus_req_s  = 1'b0;
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
            end
            default: begin
                dbus_req_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops the bus request and any response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r         <= 1'b0;
            func3_r      <= 3'd0;
            off_r        <= 2'd0;
            cnt_r        <= '0;
            dbus_req_r   <= 1'b0;
            dbus_we_r    <= 1'b0;
            dbus_addr_r  <= 32'd0;
            dbus_wdata_r <= 32'd0;
            dbus_be_r    <= 4'd0;
            rsp_valid_r  <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp_rdata_r  <= 32'd0;
        end else begin
            we_r         <= we_s;
            func3_r      <= func3_s;
            off_r        <= off_s;
            cnt_r        <= cnt_s;
            dbus_req_r   <= dbus_req_s;
            dbus_we_r    <= dbus_we_s;
            dbus_addr_r  <= dbus_addr_s;
            dbus_wdata_r <= dbus_wdata_s;
            dbus_be_r    <= dbus_be_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_err_r    <= rsp_err_s;
            rsp_rdata_r  <= rsp_rdata_s;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit (built with TIMEOUT=8).
// A vector table covers single transactions; hand-written sequences cover
// timeout, rvalid/timeout collision and reset in the middle of a transaction.

module tb_dmem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_en;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    int checks;
    int failures;

    dmem_access_unit #(.TIMEOUT(32'd8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .req_func3   (req_func3),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_be     (dbus_be),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  func3;
        logic [31:0] bus_rdata;
        int          gnt_dly;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [2:0] func3);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wdata;
        req_byte_en = be;
        req_func3   = func3;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic check_bus(input int idx, input vec_t v);
        check($sformatf("v%0d_dbus_req", idx), 32'(dbus_req), 32'd1);
        check($sformatf("v%0d_dbus_we", idx), 32'(dbus_we), 32'(v.we));
        check($sformatf("v%0d_dbus_addr", idx), dbus_addr, v.exp_addr);
        check($sformatf("v%0d_dbus_wdata", idx), dbus_wdata, v.exp_wdata);
        check($sformatf("v%0d_dbus_be", idx), 32'(dbus_be), 32'(v.exp_be));
        check($sformatf("v%0d_ready_busy", idx), 32'(req_ready), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        present(v.we, v.addr, v.wdata, v.be, v.func3);
        if (v.exp_err) begin
            check($sformatf("v%0d_err_no_req", idx), 32'(dbus_req), 32'd0);
            check($sformatf("v%0d_err_no_rsp_yet", idx), 32'(rsp_valid), 32'd0);
            tick();
            check($sformatf("v%0d_err_rsp_valid", idx), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_err_rsp_err", idx), 32'(rsp_err), 32'd1);
            check($sformatf("v%0d_err_rdata", idx), rsp_rdata, 32'd0);
            check($sformatf("v%0d_err_ready", idx), 32'(req_ready), 32'd1);
            check($sformatf("v%0d_err_still_no_req", idx), 32'(dbus_req), 32'd0);
        end else begin
            for (int c = 0; c < v.gnt_dly; c++) begin
                check_bus(idx, v);
                tick();
            end
            check_bus(idx, v);
            dbus_gnt = 1'b1;
            tick();
            dbus_gnt = 1'b0;
            check($sformatf("v%0d_req_dropped", idx), 32'(dbus_req), 32'd0);
            check($sformatf("v%0d_ready_wait", idx), 32'(req_ready), 32'd0);
            dbus_rvalid = 1'b1;
            dbus_rdata  = v.bus_rdata;
            tick();
            dbus_rvalid = 1'b0;
            dbus_rdata  = 32'd0;
            check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'd0);
            check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
            check($sformatf("v%0d_ready_with_rsp", idx), 32'(req_ready), 32'd1);
        end
        tick();
        check($sformatf("v%0d_rsp_pulse_end", idx), 32'(rsp_valid), 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [2:0] func3,
                                input logic [31:0] bus_rdata, input int gnt_dly,
                                input logic exp_err, input logic [31:0] exp_addr,
                                input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.func3 = func3;
        v.bus_rdata = bus_rdata; v.gnt_dly = gnt_dly; v.exp_err = exp_err;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        req_byte_en = 4'd0;
        req_func3   = 3'd0;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;

        //         we    addr          wdata         be       f3    bus_rdata     dly err  exp_addr      exp_wdata     exp_be   exp_rdata
        vecs[0]  = mk(1'b1, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 3'd0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0000_0000);
        vecs[1]  = mk(1'b0, 32'h0000_2002, 32'h0000_0000, 4'b0000, 3'd0, 32'h1280_FF34, 0, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'hFFFF_FF80);
        vecs[2]  = mk(1'b0, 32'h0000_2002, 32'h0000_0000, 4'b0000, 3'd4, 32'h1280_FF34, 1, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'h0000_0080);
        vecs[3]  = mk(1'b0, 32'h0000_2002, 32'h0000_0000, 4'b0000, 3'd1, 32'h1280_FF34, 0, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'h0000_1280);
        vecs[4]  = mk(1'b1, 32'h0000_0006, 32'h0000_BEEF, 4'b1100, 3'd1, 32'h0000_0000, 3, 1'b0, 32'h0000_0004, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0000);
        vecs[5]  = mk(1'b0, 32'h0000_2001, 32'h0000_0000, 4'b0000, 3'd2, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000);
        vecs[6]  = mk(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111, 3'd3, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000);
        vecs[7]  = mk(1'b0, 32'h0000_3004, 32'h0000_0000, 4'b0000, 3'd2, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_3004, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D);
        vecs[8]  = mk(1'b0, 32'h0000_2000, 32'h0000_0000, 4'b0000, 3'd5, 32'h1234_8001, 0, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'h0000_8001);
        vecs[9]  = mk(1'b0, 32'h0000_2000, 32'h0000_0000, 4'b0000, 3'd1, 32'h1234_8001, 0, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'hFFFF_8001);
        vecs[10] = mk(1'b1, 32'h0000_0040, 32'h1122_3344, 4'b1111, 3'd2, 32'h0000_0000, 0, 1'b0, 32'h0000_0040, 32'h1122_3344, 4'b1111, 32'h0000_0000);
        vecs[11] = mk(1'b0, 32'h0000_2001, 32'h0000_0000, 4'b0000, 3'd0, 32'h0000_7F00, 0, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'h0000_007F);
        vecs[12] = mk(1'b1, 32'h0000_3000, 32'h0000_0011, 4'b0001, 3'd4, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000);
        vecs[13] = mk(1'b0, 32'h0000_2003, 32'h0000_0000, 4'b0000, 3'd1, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000);

        // Reset state
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_dbus_req", 32'(dbus_req), 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_be", 32'(dbus_be), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: gnt never arrives, error exactly 8 cycles after entering REQ
        present(1'b0, 32'h0000_4000, 32'd0, 4'd0, 3'd2);
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("to_req_c%0d", i), 32'(dbus_req), 32'd1);
            check($sformatf("to_no_rsp_c%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_rdata", rsp_rdata, 32'd0);
        check("to_req_dropped", 32'(dbus_req), 32'd0);
        check("to_ready", 32'(req_ready), 32'd1);
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h5555_5555;
        tick();
        dbus_rvalid = 1'b0;
        check("late_rvalid_no_rsp", 32'(rsp_valid), 32'd0);
        check("late_rvalid_ready", 32'(req_ready), 32'd1);

        // rvalid in REQ ignored; rvalid in the timeout cycle wins
        present(1'b0, 32'h0000_5000, 32'd0, 4'd0, 3'd2);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0BAD_0BAD;
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            check($sformatf("race_no_rsp_c%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h7654_3210;
        tick();
        dbus_rvalid = 1'b0;
        check("race_rsp_valid", 32'(rsp_valid), 32'd1);
        check("race_rsp_err", 32'(rsp_err), 32'd0);
        check("race_rsp_rdata", rsp_rdata, 32'h7654_3210);
        tick();

        // Reset while waiting for the response
        present(1'b0, 32'h0000_6000, 32'd0, 4'd0, 3'd2);
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        check("mid_in_wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h9999_9999;
        #1;
        check("mid_rst_req", 32'(dbus_req), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("mid_rst_rsp_hold", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        dbus_rvalid = 1'b0;
        tick();
        check("mid_rst_rel_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rel_rsp", 32'(rsp_valid), 32'd0);
        run_vec(100, vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
